// File: rtl/set_associative_instruction_cache_pkg.sv
// Shared constants, FSM encoding and geometry helpers for the set-associative instruction cache.
// Geometry helpers are functions so every file derives widths from the same formulas.
package set_associative_instruction_cache_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_t;

  function automatic int offset_bits(input int word_per_block);
    return $clog2(word_per_block) + 2;
  endfunction

  function automatic int set_count(input int cache_size, input int ways, input int word_per_block);
    return cache_size / (ways * word_per_block * 4);
  endfunction

  function automatic int l2_bus_width(input int data_width, input int word_per_block);
    return data_width * word_per_block;
  endfunction

endpackage

// File: rtl/set_associative_instruction_cache_if.sv
// Fetch-side and L2-side signal bundle of the instruction cache.
// The cache uses the slave modport; the fetch stage / L2 environment uses master.
interface set_associative_instruction_cache_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_PER_BLOCK = 16
);
  import set_associative_instruction_cache_pkg::*;

  localparam int OFFSET       = offset_bits(WORD_PER_BLOCK);
  localparam int L2_BUS_WIDTH = l2_bus_width(DATA_WIDTH, WORD_PER_BLOCK);

  logic                      STALL_INSTRUCTION_CACHE;
  logic [ADDRESS_WIDTH-1:0]  PC;
  logic                      PC_VALID;
  logic                      INVALIDATE;
  logic [DATA_WIDTH-1:0]     INSTRUCTION;
  logic                      INSTRUCTION_VALID;
  logic                      INSTRUCTION_CACHE_READY;
  logic                      ADDRESS_TO_L2_READY_INS;
  logic                      ADDRESS_TO_L2_VALID_INS;
  logic [ADDRESS_WIDTH-OFFSET-1:0] ADDRESS_TO_L2_INS;
  logic                      DATA_FROM_L2_READY_INS;
  logic                      DATA_FROM_L2_VALID_INS;
  logic [L2_BUS_WIDTH-1:0]   DATA_FROM_L2_INS;

  modport slave (
    input  STALL_INSTRUCTION_CACHE, PC, PC_VALID, INVALIDATE,
    input  ADDRESS_TO_L2_READY_INS, DATA_FROM_L2_VALID_INS, DATA_FROM_L2_INS,
    output INSTRUCTION, INSTRUCTION_VALID, INSTRUCTION_CACHE_READY,
    output ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_INS, DATA_FROM_L2_READY_INS
  );

  modport master (
    output STALL_INSTRUCTION_CACHE, PC, PC_VALID, INVALIDATE,
    output ADDRESS_TO_L2_READY_INS, DATA_FROM_L2_VALID_INS, DATA_FROM_L2_INS,
    input  INSTRUCTION, INSTRUCTION_VALID, INSTRUCTION_CACHE_READY,
    input  ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_INS, DATA_FROM_L2_READY_INS
  );

endinterface

// File: rtl/set_associative_instruction_cache_icache_way.sv
// One cache way: valid/tag/data arrays with combinational read and the tag comparator.
// Lookup and write share one index port; the top steers it to PC or the pending miss.
module icache_way
  import set_associative_instruction_cache_pkg::*;
#(
  parameter int SETS           = 8,
  parameter int INDEX          = 3,
  parameter int TAG            = 25,
  parameter int WORD_PER_BLOCK = 4,
  parameter int DATA_WIDTH     = 32,
  localparam int LINE_WIDTH    = DATA_WIDTH * WORD_PER_BLOCK,
  localparam int WORD_BITS     = $clog2(WORD_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  invalidate,
  input  logic [INDEX-1:0]      lookup_index,
  input  logic [TAG-1:0]        lookup_tag,
  input  logic [WORD_BITS-1:0]  lookup_word,
  output logic                  lookup_valid,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] word,
  input  logic                  write_en,
  input  logic [TAG-1:0]        write_tag,
  input  logic [LINE_WIDTH-1:0] write_line
);

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG-1:0]        tag_q  [SETS];
  logic [LINE_WIDTH-1:0] data_q [SETS];

  // Invalidate is applied last so it beats a coincident refill.
  always_comb begin
    valid_d = valid_q;
    if (write_en) valid_d[lookup_index] = HIGH;
    if (invalidate) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_q[lookup_index]  <= write_tag;
      data_q[lookup_index] <= write_line;
    end
  end

  assign lookup_valid = valid_q[lookup_index];
  assign hit          = lookup_valid && (tag_q[lookup_index] == lookup_tag);
  assign word         = data_q[lookup_index][lookup_word*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/set_associative_instruction_cache.sv
// Blocking N-way set-associative L1 instruction cache with round-robin replacement
// and a single-beat L2 line refill; FSM RUN -> REQ -> WAIT -> FILL on a miss.
module set_associative_instruction_cache
  import set_associative_instruction_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CACHE_SIZE     = 64*1024,
  parameter int WORD_PER_BLOCK = 16,
  parameter int WAYS           = 2
) (
  input logic CLK,
  input logic RST,
  set_associative_instruction_cache_if.slave bus
);

  localparam int OFFSET    = offset_bits(WORD_PER_BLOCK);
  localparam int SETS      = set_count(CACHE_SIZE, WAYS, WORD_PER_BLOCK);
  localparam int INDEX     = $clog2(SETS);
  localparam int TAG       = ADDRESS_WIDTH - INDEX - OFFSET;
  localparam int WORD_BITS = OFFSET - 2;
  localparam int WAY_BITS  = $clog2(WAYS);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:2] miss_pc_q, miss_pc_d;
  logic [DATA_WIDTH-1:0]    instruction_q, instruction_d;
  logic                     instruction_valid_q, instruction_valid_d;
  logic [WAY_BITS-1:0]      rr_q [SETS];
  logic [WAY_BITS-1:0]      rr_d [SETS];

  logic                     accept, fill, hit_any, victim_found, unused_pc_bits;
  logic [ADDRESS_WIDTH-1:2] lookup_pc;
  logic [INDEX-1:0]         lookup_index;
  logic [TAG-1:0]           lookup_tag;
  logic [WORD_BITS-1:0]     lookup_word;
  logic [WAYS-1:0]          way_hit, way_valid, way_write;
  logic [DATA_WIDTH-1:0]    way_word [WAYS];
  logic [DATA_WIDTH-1:0]    hit_word, fill_word;
  logic [WAY_BITS-1:0]      victim;

  assign unused_pc_bits = ^bus.PC[1:0];
  assign accept    = (state_q == RUN) && bus.PC_VALID && !bus.STALL_INSTRUCTION_CACHE;
  assign fill      = (state_q == WAIT) && bus.DATA_FROM_L2_VALID_INS;
  // Outside RUN the arrays are addressed by the pending miss for victim choice and refill.
  assign lookup_pc    = (state_q == RUN) ? bus.PC[ADDRESS_WIDTH-1:2] : miss_pc_q;
  assign lookup_index = lookup_pc[OFFSET+INDEX-1:OFFSET];
  assign lookup_tag   = lookup_pc[ADDRESS_WIDTH-1:OFFSET+INDEX];
  assign lookup_word  = lookup_pc[OFFSET-1:2];
  assign fill_word    = bus.DATA_FROM_L2_INS[lookup_word*DATA_WIDTH +: DATA_WIDTH];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_write[w] = fill && (victim == WAY_BITS'(w));
    icache_way #(
      .SETS(SETS), .INDEX(INDEX), .TAG(TAG),
      .WORD_PER_BLOCK(WORD_PER_BLOCK), .DATA_WIDTH(DATA_WIDTH)
    ) u_way (
      .clk(CLK), .rst(RST), .invalidate(bus.INVALIDATE),
      .lookup_index(lookup_index), .lookup_tag(lookup_tag), .lookup_word(lookup_word),
      .lookup_valid(way_valid[w]), .hit(way_hit[w]), .word(way_word[w]),
      .write_en(way_write[w]), .write_tag(lookup_tag), .write_line(bus.DATA_FROM_L2_INS)
    );
  end

  always_comb begin
    hit_any  = LOW;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = HIGH;
        hit_word = hit_word | way_word[w];
      end
    end
  end

  // Lowest invalid way first, otherwise the set's round-robin pointer.
  always_comb begin
    victim       = rr_q[lookup_index];
    victim_found = LOW;
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !victim_found) begin
        victim       = WAY_BITS'(w);
        victim_found = HIGH;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q             <= RUN;
      miss_pc_q           <= '0;
      instruction_q       <= '0;
      instruction_valid_q <= LOW;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q             <= state_d;
      miss_pc_q           <= miss_pc_d;
      instruction_q       <= instruction_d;
      instruction_valid_q <= instruction_valid_d;
      rr_q                <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && !hit_any) state_d = REQ;
      REQ:     if (bus.ADDRESS_TO_L2_READY_INS) state_d = WAIT;
      WAIT:    if (bus.DATA_FROM_L2_VALID_INS) state_d = FILL;
      FILL:    if (!bus.STALL_INSTRUCTION_CACHE) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Stall freezes the fetch-side registers, but a refill beat always lands.
  always_comb begin
    miss_pc_d           = miss_pc_q;
    instruction_d       = instruction_q;
    instruction_valid_d = instruction_valid_q;
    rr_d                = rr_q;
    if ((state_q == RUN) && !bus.STALL_INSTRUCTION_CACHE) begin
      if (accept && hit_any) begin
        instruction_d       = hit_word;
        instruction_valid_d = HIGH;
      end else if (accept) begin
        miss_pc_d           = bus.PC[ADDRESS_WIDTH-1:2];
        instruction_valid_d = LOW;
      end else begin
        instruction_valid_d = LOW;
      end
    end
    if (fill) begin
      instruction_d        = fill_word;
      instruction_valid_d  = HIGH;
      rr_d[lookup_index]   = victim + WAY_BITS'(1);
    end
  end

  always_comb begin
    bus.INSTRUCTION_CACHE_READY = (state_q == RUN);
    bus.ADDRESS_TO_L2_VALID_INS = (state_q == REQ);
    bus.DATA_FROM_L2_READY_INS  = (state_q == WAIT);
  end

  assign bus.ADDRESS_TO_L2_INS = miss_pc_q[ADDRESS_WIDTH-1:OFFSET];
  assign bus.INSTRUCTION       = instruction_q;
  assign bus.INSTRUCTION_VALID = instruction_valid_q;

endmodule

// File: tb/tb_set_associative_instruction_cache.sv
// Directed bench for set_associative_instruction_cache in a 256-byte, 4-word-line, 2-way
// configuration (8 sets, index PC[6:4], word PC[3:2]); the L2 is modelled inside fetch().
module tb_set_associative_instruction_cache;

  localparam int AW = 32, DW = 32, CS = 256, WPB = 4, WAYS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;

  // Results of the most recent fetch() call.
  logic [31:0] f_instr;
  logic [27:0] f_req_addr;
  bit          f_saw_req, f_addr_changed, f_ready_seen, f_timeout;
  int          f_req_cycles, f_lat;

  set_associative_instruction_cache_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WORD_PER_BLOCK(WPB)) bus ();

  set_associative_instruction_cache #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_SIZE(CS), .WORD_PER_BLOCK(WPB), .WAYS(WAYS)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] l2_word(input logic [27:0] line_addr, input int w);
    return {line_addr[23:0], 8'hA0 + 8'(w)};
  endfunction

  function automatic logic [127:0] l2_line(input logic [27:0] line_addr);
    logic [127:0] line;
    for (int w = 0; w < 4; w++) line[32*w +: 32] = l2_word(line_addr, w);
    return line;
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] pc);
    return l2_word(pc[31:4], int'(pc[3:2]));
  endfunction

  task automatic wait_ready();
    for (int g = 0; g < 20 && !bus.INSTRUCTION_CACHE_READY; g++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issues one fetch, plays the L2 side and returns once INSTRUCTION_VALID is seen.
  task automatic fetch(input logic [31:0] addr, input int l2_delay, input bit inval_on_data);
    int wait_cnt = 0;
    f_instr = '0; f_req_addr = '0; f_saw_req = 0; f_addr_changed = 0;
    f_ready_seen = 0; f_timeout = 1; f_req_cycles = 0; f_lat = 0;
    wait_ready();
    bus.PC = addr;
    bus.PC_VALID = 1'b1;
    @(posedge clk); #1;
    bus.PC_VALID = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.INVALIDATE = 1'b0;
      if (bus.ADDRESS_TO_L2_VALID_INS) begin
        if (f_saw_req && bus.ADDRESS_TO_L2_INS !== f_req_addr) f_addr_changed = 1;
        f_saw_req = 1;
        f_req_addr = bus.ADDRESS_TO_L2_INS;
        f_req_cycles++;
        bus.ADDRESS_TO_L2_READY_INS = (wait_cnt >= l2_delay);
        wait_cnt++;
      end else begin
        bus.ADDRESS_TO_L2_READY_INS = 1'b0;
      end
      if (bus.DATA_FROM_L2_READY_INS) begin
        bus.DATA_FROM_L2_VALID_INS = 1'b1;
        bus.DATA_FROM_L2_INS = l2_line(f_req_addr);
        bus.INVALIDATE = inval_on_data;
      end else begin
        bus.DATA_FROM_L2_VALID_INS = 1'b0;
      end
      if (bus.INSTRUCTION_CACHE_READY && !bus.INSTRUCTION_VALID) f_ready_seen = 1;
      if (bus.INSTRUCTION_VALID) begin
        f_instr = bus.INSTRUCTION;
        f_lat = c;
        f_timeout = 0;
        break;
      end
      @(posedge clk); #1;
    end
    bus.ADDRESS_TO_L2_READY_INS = 1'b0;
    bus.DATA_FROM_L2_VALID_INS = 1'b0;
    bus.INVALIDATE = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.INSTRUCTION !== 32'h0) $display("[TB] FAIL reset_instruction: got %h, expected %h", bus.INSTRUCTION, 32'h0); else passed++;
    checks++; if (bus.INSTRUCTION_VALID !== 1'b0) $display("[TB] FAIL reset_valid: got %b, expected 0", bus.INSTRUCTION_VALID); else passed++;
    checks++; if (bus.INSTRUCTION_CACHE_READY !== 1'b1) $display("[TB] FAIL reset_ready: got %b, expected 1", bus.INSTRUCTION_CACHE_READY); else passed++;
    checks++; if (bus.ADDRESS_TO_L2_VALID_INS !== 1'b0) $display("[TB] FAIL reset_l2_valid: got %b, expected 0", bus.ADDRESS_TO_L2_VALID_INS); else passed++;
    checks++; if (bus.ADDRESS_TO_L2_INS !== 28'h0) $display("[TB] FAIL reset_l2_addr: got %h, expected %h", bus.ADDRESS_TO_L2_INS, 28'h0); else passed++;
    checks++; if (bus.DATA_FROM_L2_READY_INS !== 1'b0) $display("[TB] FAIL reset_data_ready: got %b, expected 0", bus.DATA_FROM_L2_READY_INS); else passed++;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0008, 0, 0);
    checks++; if (f_timeout !== 1'b0) $display("[TB] FAIL cold_timeout: got %b, expected 0", f_timeout); else passed++;
    checks++; if (f_saw_req !== 1'b1) $display("[TB] FAIL cold_req: got %b, expected 1", f_saw_req); else passed++;
    checks++; if (f_req_addr !== 28'h0) $display("[TB] FAIL cold_req_addr: got %h, expected %h", f_req_addr, 28'h0); else passed++;
    checks++; if (f_instr !== expect_word(32'h8)) $display("[TB] FAIL cold_instr: got %h, expected %h", f_instr, expect_word(32'h8)); else passed++;
    checks++; if (bus.INSTRUCTION_CACHE_READY !== 1'b0) $display("[TB] FAIL cold_fill_ready: got %b, expected 0", bus.INSTRUCTION_CACHE_READY); else passed++;
    fetch(32'h0000_000C, 0, 0);
    checks++; if (f_saw_req !== 1'b0) $display("[TB] FAIL hit_req: got %b, expected 0", f_saw_req); else passed++;
    checks++; if (f_instr !== expect_word(32'hC)) $display("[TB] FAIL hit_instr: got %h, expected %h", f_instr, expect_word(32'hC)); else passed++;
    checks++; if (f_lat !== 0) $display("[TB] FAIL hit_latency: got %0d, expected 0", f_lat); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    wait_ready();
    bus.PC_VALID = 1'b1;
    for (int w = 0; w < 4; w++) begin
      pc = 32'(w * 4);
      bus.PC = pc;
      @(posedge clk); #1;
      checks++;
      if ({bus.INSTRUCTION_VALID, bus.INSTRUCTION} !== {1'b1, expect_word(pc)})
        $display("[TB] FAIL b2b_word%0d: got %b/%h, expected 1/%h", w, bus.INSTRUCTION_VALID, bus.INSTRUCTION, expect_word(pc));
      else passed++;
    end
    bus.PC_VALID = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.INSTRUCTION_VALID !== 1'b0) $display("[TB] FAIL idle_clears_valid: got %b, expected 0", bus.INSTRUCTION_VALID); else passed++;
  endtask

  task automatic test_conflict();
    logic [31:0] pcs [7] = '{32'h000, 32'h080, 32'h100, 32'h080, 32'h000, 32'h100, 32'h080};
    bit          miss [7] = '{1, 1, 1, 0, 1, 0, 1};
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      fetch(pcs[i], 0, 0);
      checks++; if (f_saw_req !== miss[i]) $display("[TB] FAIL conflict_miss%0d pc=%h: got %b, expected %b", i, pcs[i], f_saw_req, miss[i]); else passed++;
      checks++; if (f_instr !== expect_word(pcs[i])) $display("[TB] FAIL conflict_instr%0d: got %h, expected %h", i, f_instr, expect_word(pcs[i])); else passed++;
      if (miss[i]) begin
        checks++; if (f_req_addr !== pcs[i][31:4]) $display("[TB] FAIL conflict_addr%0d: got %h, expected %h", i, f_req_addr, pcs[i][31:4]); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    fetch(32'h0000_0044, 5, 0);
    checks++; if (f_req_cycles !== 6) $display("[TB] FAIL bp_req_cycles: got %0d, expected 6", f_req_cycles); else passed++;
    checks++; if (f_addr_changed !== 1'b0) $display("[TB] FAIL bp_addr_stable: got %b, expected 0", f_addr_changed); else passed++;
    checks++; if (f_ready_seen !== 1'b0) $display("[TB] FAIL bp_ready_low: got %b, expected 0", f_ready_seen); else passed++;
    checks++; if (f_req_addr !== 28'h4) $display("[TB] FAIL bp_addr: got %h, expected %h", f_req_addr, 28'h4); else passed++;
    checks++; if (f_instr !== expect_word(32'h44)) $display("[TB] FAIL bp_instr: got %h, expected %h", f_instr, expect_word(32'h44)); else passed++;
  endtask

  task automatic test_stall();
    bit held;
    wait_ready();
    bus.PC = 32'h44;
    bus.PC_VALID = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.INSTRUCTION_VALID, bus.INSTRUCTION} !== {1'b1, expect_word(32'h44)}) $display("[TB] FAIL stall_hit: got %b/%h, expected 1/%h", bus.INSTRUCTION_VALID, bus.INSTRUCTION, expect_word(32'h44)); else passed++;
    bus.STALL_INSTRUCTION_CACHE = 1'b1;
    bus.PC = 32'h48;
    held = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if ({bus.INSTRUCTION_VALID, bus.INSTRUCTION} !== {1'b1, expect_word(32'h44)}) held = 0;
    end
    checks++; if (held !== 1'b1) $display("[TB] FAIL stall_hit_hold: got %b, expected 1", held); else passed++;
    bus.STALL_INSTRUCTION_CACHE = 1'b0;
    bus.PC_VALID = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.INSTRUCTION_VALID !== 1'b0) $display("[TB] FAIL stall_release_valid: got %b, expected 0", bus.INSTRUCTION_VALID); else passed++;

    fetch(32'h0000_0054, 0, 0);
    bus.STALL_INSTRUCTION_CACHE = 1'b1;
    checks++; if (f_instr !== expect_word(32'h54)) $display("[TB] FAIL stall_fill_instr: got %h, expected %h", f_instr, expect_word(32'h54)); else passed++;
    held = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if ({bus.INSTRUCTION_CACHE_READY, bus.INSTRUCTION_VALID, bus.INSTRUCTION} !== {1'b0, 1'b1, expect_word(32'h54)}) held = 0;
    end
    checks++; if (held !== 1'b1) $display("[TB] FAIL stall_fill_hold: got %b, expected 1", held); else passed++;
    bus.STALL_INSTRUCTION_CACHE = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.INSTRUCTION_CACHE_READY !== 1'b1) $display("[TB] FAIL stall_fill_exit: got %b, expected 1", bus.INSTRUCTION_CACHE_READY); else passed++;
  endtask

  task automatic test_invalidate();
    wait_ready();
    bus.INVALIDATE = 1'b1;
    @(posedge clk); #1;
    bus.INVALIDATE = 1'b0;
    fetch(32'h0000_0054, 0, 0);
    checks++; if (f_saw_req !== 1'b1) $display("[TB] FAIL inval_refetch_miss: got %b, expected 1", f_saw_req); else passed++;
    checks++; if (f_instr !== expect_word(32'h54)) $display("[TB] FAIL inval_refetch_instr: got %h, expected %h", f_instr, expect_word(32'h54)); else passed++;
    fetch(32'h0000_0044, 0, 0);
    checks++; if (f_saw_req !== 1'b1) $display("[TB] FAIL inval_other_line_miss: got %b, expected 1", f_saw_req); else passed++;

    fetch(32'h0000_0064, 1, 1);
    checks++; if (f_instr !== expect_word(32'h64)) $display("[TB] FAIL inval_beat_instr: got %h, expected %h", f_instr, expect_word(32'h64)); else passed++;
    fetch(32'h0000_0064, 0, 0);
    checks++; if (f_saw_req !== 1'b1) $display("[TB] FAIL inval_beat_next_miss: got %b, expected 1", f_saw_req); else passed++;
    fetch(32'h0000_0068, 0, 0);
    checks++; if (f_saw_req !== 1'b0) $display("[TB] FAIL inval_refill_hit: got %b, expected 0", f_saw_req); else passed++;
    checks++; if (f_instr !== expect_word(32'h68)) $display("[TB] FAIL inval_refill_instr: got %h, expected %h", f_instr, expect_word(32'h68)); else passed++;
  endtask

  task automatic test_rst_in_wait();
    wait_ready();
    bus.PC = 32'h74;
    bus.PC_VALID = 1'b1;
    @(posedge clk); #1;
    bus.PC_VALID = 1'b0;
    checks++; if (bus.ADDRESS_TO_L2_VALID_INS !== 1'b1) $display("[TB] FAIL rst_req_state: got %b, expected 1", bus.ADDRESS_TO_L2_VALID_INS); else passed++;
    bus.ADDRESS_TO_L2_READY_INS = 1'b1;
    @(posedge clk); #1;
    bus.ADDRESS_TO_L2_READY_INS = 1'b0;
    checks++; if (bus.DATA_FROM_L2_READY_INS !== 1'b1) $display("[TB] FAIL rst_wait_state: got %b, expected 1", bus.DATA_FROM_L2_READY_INS); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.INSTRUCTION_CACHE_READY, bus.DATA_FROM_L2_READY_INS, bus.ADDRESS_TO_L2_VALID_INS, bus.INSTRUCTION_VALID} !== 4'b1000)
      $display("[TB] FAIL rst_async_flags: got %b, expected 1000", {bus.INSTRUCTION_CACHE_READY, bus.DATA_FROM_L2_READY_INS, bus.ADDRESS_TO_L2_VALID_INS, bus.INSTRUCTION_VALID});
    else passed++;
    checks++; if (bus.INSTRUCTION !== 32'h0) $display("[TB] FAIL rst_async_instr: got %h, expected %h", bus.INSTRUCTION, 32'h0); else passed++;
    checks++; if (bus.ADDRESS_TO_L2_INS !== 28'h0) $display("[TB] FAIL rst_async_addr: got %h, expected %h", bus.ADDRESS_TO_L2_INS, 28'h0); else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    fetch(32'h0000_0074, 0, 0);
    checks++; if (f_saw_req !== 1'b1) $display("[TB] FAIL rst_refetch_miss: got %b, expected 1", f_saw_req); else passed++;
    checks++; if (f_instr !== expect_word(32'h74)) $display("[TB] FAIL rst_refetch_instr: got %h, expected %h", f_instr, expect_word(32'h74)); else passed++;
    fetch(32'h0000_0068, 0, 0);
    checks++; if (f_saw_req !== 1'b1) $display("[TB] FAIL rst_cleared_line: got %b, expected 1", f_saw_req); else passed++;
  endtask

  initial begin
    bus.STALL_INSTRUCTION_CACHE = 1'b0;
    bus.PC = '0;
    bus.PC_VALID = 1'b0;
    bus.INVALIDATE = 1'b0;
    bus.ADDRESS_TO_L2_READY_INS = 1'b0;
    bus.DATA_FROM_L2_VALID_INS = 1'b0;
    bus.DATA_FROM_L2_INS = '0;
    $display("[TB] starting instruction cache bench");
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_backpressure();
    test_stall();
    test_invalidate();
    test_rst_in_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
